// File: rtl/seq_match_stats_pkg.sv
// Shared definitions for the sequence-detector result stream and its stats records.
// A record is packed as {match_cnt, miss_cnt, run_max}, each field CW bits wide.
package seq_match_stats_pkg;

    typedef enum logic [1:0] {
        RES_NONE  = 2'd0,
        RES_MATCH = 2'd1,
        RES_MISS  = 2'd2
    } res_e;

    localparam int REC_FIELDS = 3;

    // A simultaneous match/not_match is treated as a miss.
    function automatic res_e classify(input logic m, input logic n);
        if (n)      return RES_MISS;
        else if (m) return RES_MATCH;
        else        return RES_NONE;
    endfunction

endpackage

// File: rtl/seq_rec_fifo2.sv
// Two-entry FIFO holding completed window records; head is always on dout.
module seq_rec_fifo2 #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    logic [W-1:0] e0, e1;
    logic [1:0]   cnt;

    assign dout  = e0;
    assign full  = (cnt == 2'd2);
    assign empty = (cnt == 2'd0);

    // A pop is only honoured with data present; a push only with room after the pop.
    logic do_pop, do_push;
    assign do_pop  = pop & !empty;
    assign do_push = push & (!full | do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            e0  <= '0;
            e1  <= '0;
            cnt <= 2'd0;
        end else begin
            case (cnt)
                2'd0: begin
                    if (do_push) begin
                        e0  <= din;
                        cnt <= 2'd1;
                    end
                end
                2'd1: begin
                    if (do_push && do_pop) begin
                        e0 <= din;
                    end else if (do_push) begin
                        e1  <= din;
                        cnt <= 2'd2;
                    end else if (do_pop) begin
                        cnt <= 2'd0;
                    end
                end
                default: begin
                    if (do_pop) begin
                        e0 <= e1;
                        if (do_push) e1 <= din;
                        else         cnt <= 2'd1;
                    end
                end
            endcase
        end
    end
endmodule

// File: rtl/seq_match_stats.sv
// Windowed statistics over detector result pulses: per-window match/miss counts
// and longest match run, queued through a 2-entry valid/ready record port.
module seq_match_stats
    import seq_match_stats_pkg::*;
#(
    parameter int WIN = 8,
    localparam int CW = $clog2(WIN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          match,
    input  logic          not_match,
    input  logic          clr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] out_match_cnt,
    output logic [CW-1:0] out_miss_cnt,
    output logic [CW-1:0] out_run_max,
    output logic          drop_sticky,
    output logic          proto_err
);
    localparam int RW = REC_FIELDS * CW;

    logic [CW-1:0] ev_cnt, match_cnt, miss_cnt, cur_run, run_max;
    logic [CW-1:0] ev_nx, match_nx, miss_nx, cur_nx, run_nx;
    logic          close;
    res_e          res;

    assign res = classify(match, not_match);

    always_comb begin
        ev_nx    = ev_cnt;
        match_nx = match_cnt;
        miss_nx  = miss_cnt;
        cur_nx   = cur_run;
        run_nx   = run_max;
        close    = 1'b0;
        if (res != RES_NONE) begin
            ev_nx = ev_cnt + CW'(1);
            if (res == RES_MATCH) begin
                match_nx = match_cnt + CW'(1);
                cur_nx   = cur_run + CW'(1);
            end else begin
                miss_nx = miss_cnt + CW'(1);
                cur_nx  = '0;
            end
            run_nx = (cur_nx > run_max) ? cur_nx : run_max;
            close  = (ev_cnt == CW'(WIN - 1));
        end
    end

    // Window state; a closing event flushes it so runs never span windows.
    always_ff @(posedge clk) begin
        if (rst || clr || (close && !clr)) begin
            ev_cnt    <= '0;
            match_cnt <= '0;
            miss_cnt  <= '0;
            cur_run   <= '0;
            run_max   <= '0;
        end else begin
            ev_cnt    <= ev_nx;
            match_cnt <= match_nx;
            miss_cnt  <= miss_nx;
            cur_run   <= cur_nx;
            run_max   <= run_nx;
        end
    end

    logic          push, pop, full, empty, drop;
    logic [RW-1:0] rec_in, rec_out;

    assign push      = close & !clr;
    assign rec_in    = {match_nx, miss_nx, run_nx};
    assign out_valid = !empty;
    assign pop       = out_valid & out_ready;
    assign drop      = push & full & !pop;

    assign {out_match_cnt, out_miss_cnt, out_run_max} = rec_out;

    seq_rec_fifo2 #(.W(RW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (rec_in),
        .dout  (rec_out),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            drop_sticky <= 1'b0;
            proto_err   <= 1'b0;
        end else begin
            if (drop)              drop_sticky <= 1'b1;
            if (match & not_match) proto_err   <= 1'b1;
        end
    end
endmodule

// File: tb/tb_seq_match_stats.sv
// Randomized scoreboard bench for seq_match_stats with a window-list reference model.
module tb_seq_match_stats;
    localparam int WIN = 4;
    localparam int CW  = $clog2(WIN + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          match = 1'b0, not_match = 1'b0, clr = 1'b0, out_ready = 1'b0;
    logic          out_valid, drop_sticky, proto_err;
    logic [CW-1:0] out_match_cnt, out_miss_cnt, out_run_max;

    seq_match_stats #(.WIN(WIN)) dut (
        .clk(clk), .rst(rst), .match(match), .not_match(not_match), .clr(clr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_match_cnt(out_match_cnt), .out_miss_cnt(out_miss_cnt),
        .out_run_max(out_run_max), .drop_sticky(drop_sticky), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    typedef struct { int m; int x; int r; } rec_t;

    rec_t exp_q[$];
    bit   win_q[$];
    bit   exp_drop = 0, exp_proto = 0;
    bit   mon_en = 0;
    int   n_chk = 0, n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Record from the raw list of window results: counts plus longest run of 1s.
    function automatic rec_t summarize(input bit w[$]);
        rec_t r;
        int run = 0;
        r = '{0, 0, 0};
        foreach (w[i]) begin
            if (w[i]) begin r.m++; run++; end
            else      begin r.x++; run = 0; end
            if (run > r.r) r.r = run;
        end
        return r;
    endfunction

    // Outputs are compared mid-cycle; a handshake seen here completes on the next edge.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("out_valid", int'(out_valid), int'(exp_q.size() != 0));
            chk("drop_sticky", int'(drop_sticky), int'(exp_drop));
            chk("proto_err", int'(proto_err), int'(exp_proto));
            if (out_valid && exp_q.size() != 0) begin
                chk("match_cnt", int'(out_match_cnt), exp_q[0].m);
                chk("miss_cnt", int'(out_miss_cnt), exp_q[0].x);
                chk("run_max", int'(out_run_max), exp_q[0].r);
                chk("sum_win", int'(out_match_cnt) + int'(out_miss_cnt), WIN);
                if (out_ready && !rst) void'(exp_q.pop_front());
            end
        end
    end

    // One clock of stimulus; the model advances once the edge has happened.
    task automatic cyc(input bit m, input bit n, input bit c, input bit rdy);
        int  sz;
        bit  pop;
        rec_t r;
        match = m; not_match = n; clr = c; out_ready = rdy;
        sz  = exp_q.size();
        pop = rdy && sz > 0;
        @(posedge clk);
        #1;
        if (c) begin
            win_q.delete();
            exp_drop = 0;
            exp_proto = 0;
        end else if (m || n) begin
            if (m && n) exp_proto = 1;
            win_q.push_back(m && !n);
            if (win_q.size() == WIN) begin
                r = summarize(win_q);
                win_q.delete();
                if (sz == 2 && !pop) exp_drop = 1;
                else exp_q.push_back(r);
            end
        end
        match = 0; not_match = 0; clr = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        exp_q.delete();
        win_q.delete();
        exp_drop = 0;
        exp_proto = 0;
    endtask

    task automatic window(input bit rdy);
        for (int i = 0; i < WIN; i++) cyc(1, 0, 0, rdy);
    endtask

    initial begin
        @(posedge clk); #1;
        do_reset();
        mon_en = 1;
        cyc(0, 0, 0, 1);

        // M,M,N,M -> 3/1/2
        cyc(1, 0, 0, 1); cyc(1, 0, 0, 1); cyc(0, 1, 0, 1); cyc(1, 0, 0, 1);
        cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);

        // three windows while stalled: third dropped
        cyc(1, 0, 0, 0); cyc(0, 1, 0, 0); cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
        window(0);
        cyc(0, 1, 0, 0); cyc(0, 1, 0, 0); cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);
        cyc(0, 0, 0, 0); cyc(0, 0, 0, 1); cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);

        // both pulses at once count as a miss
        cyc(1, 1, 0, 1); cyc(1, 0, 0, 1); cyc(1, 0, 0, 1); cyc(1, 0, 0, 1);
        cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);

        // clr mid-window, event in clr cycle ignored
        cyc(1, 0, 0, 1); cyc(1, 0, 0, 1); cyc(1, 0, 1, 1);
        window(1);
        cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);

        // full queue popped on the closing cycle: no loss
        window(0); window(0);
        cyc(1, 0, 0, 0); cyc(0, 1, 0, 0); cyc(1, 0, 0, 0); cyc(0, 1, 0, 1);
        cyc(0, 0, 0, 1); cyc(0, 0, 0, 1); cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);

        // reset mid-window with a record pending
        window(0);
        cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
        do_reset();
        cyc(0, 1, 0, 1); window(1);
        cyc(0, 0, 0, 1); cyc(0, 0, 0, 1);

        for (int i = 0; i < 3000; i++) begin
            int p;
            bit m, n, c, rd;
            p  = int'($urandom_range(0, 99));
            m  = (p < 40) || (p >= 95);
            n  = (p >= 40 && p < 70) || (p >= 95);
            c  = ($urandom_range(0, 99) < 2);
            rd = ($urandom_range(0, 99) < 45);
            if ($urandom_range(0, 999) < 3) do_reset();
            else cyc(m, n, c, rd);
        end
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
